// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - in-order instruction fetch with redirect drain and 2-entry decode buffer
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module pc_fetch #(
   parameter logic [`CPU_WIDTH-1:0] RESET_PC = 32'h8000_0000,
   parameter int                    MAX_OUT  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_vld,
   input  logic [`CPU_WIDTH-1:0] redirect_pc,
   output logic                  imem_req_vld,
   output logic [`CPU_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_req_rdy,
   input  logic                  imem_rsp_vld,
   input  logic [`CPU_WIDTH-1:0] imem_rsp_data,
   output logic                  idu_vld,
   output logic [`CPU_WIDTH-1:0] idu_inst,
   output logic [`CPU_WIDTH-1:0] idu_inst_pc,
   input  logic                  idu_rdy
);
   localparam int W = `CPU_WIDTH;

   typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

   state_t       state_q, state_d;
   logic [W-1:0] pc_q, pc_d;
   logic [1:0]   out_cnt_q, out_cnt_d;
   logic [1:0]   occ_q, occ_d;
   logic [1:0]   drop_cnt_q, drop_cnt_d;
   logic [W-1:0] af_q [2];
   logic [W-1:0] af_d [2];
   logic [W-1:0] buf_pc_q [2];
   logic [W-1:0] buf_pc_d [2];
   logic [W-1:0] buf_inst_q [2];
   logic [W-1:0] buf_inst_d [2];

   logic         rsp_ok;
   logic         req_acc;
   logic         buf_push;
   logic         buf_pop;
   logic [1:0]   af_wr_idx;
   logic [1:0]   buf_wr_idx;
   logic [W-1:0] redirect_tgt;

   assign idu_vld     = (occ_q != 2'd0);
   assign idu_inst    = buf_inst_q[0];
   assign idu_inst_pc = buf_pc_q[0];

   always_comb begin
      // A response with nothing outstanding is treated as if it never happened.
      rsp_ok        = imem_rsp_vld && (out_cnt_q != 2'd0);
      imem_req_vld  = (state_q == FETCH) && !redirect_vld &&
                      ((int'(out_cnt_q) + int'(occ_q)) < MAX_OUT);
      imem_req_addr = pc_q;
      req_acc       = imem_req_vld && imem_req_rdy;
      buf_push      = rsp_ok && (state_q == FETCH) && !redirect_vld;
      buf_pop       = idu_vld && idu_rdy;
      redirect_tgt  = redirect_pc & ~W'(3);

      pc_d = pc_q;
      if (redirect_vld) begin
         pc_d = redirect_tgt;
      end else if (req_acc) begin
         pc_d = pc_q + W'(4);
      end

      out_cnt_d = out_cnt_q + {1'b0, req_acc} - {1'b0, rsp_ok};

      af_d = af_q;
      if (rsp_ok) begin
         af_d[0] = af_q[1];
      end
      af_wr_idx = out_cnt_q - {1'b0, rsp_ok};
      if (req_acc) begin
         af_d[af_wr_idx[0]] = pc_q;
      end

      // Head always lives in entry 0 so idu_* come straight off flops.
      buf_pc_d   = buf_pc_q;
      buf_inst_d = buf_inst_q;
      if (buf_pop) begin
         buf_pc_d[0]   = buf_pc_q[1];
         buf_inst_d[0] = buf_inst_q[1];
      end
      buf_wr_idx = occ_q - {1'b0, buf_pop};
      if (buf_push) begin
         buf_pc_d[buf_wr_idx[0]]   = af_q[0];
         buf_inst_d[buf_wr_idx[0]] = imem_rsp_data;
      end
      occ_d = occ_q + {1'b0, buf_push} - {1'b0, buf_pop};
      if (redirect_vld) begin
         occ_d = 2'd0;
      end

      drop_cnt_d = drop_cnt_q;
      state_d    = state_q;
      unique case (state_q)
         BOOT: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (redirect_vld) begin
               drop_cnt_d = out_cnt_q - {1'b0, rsp_ok};
               if (drop_cnt_d != 2'd0) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (rsp_ok && (drop_cnt_q != 2'd0)) begin
               drop_cnt_d = drop_cnt_q - 2'd1;
            end
            if (drop_cnt_d == 2'd0) begin
               state_d = FETCH;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= BOOT;
         pc_q          <= RESET_PC;
         out_cnt_q     <= 2'd0;
         occ_q         <= 2'd0;
         drop_cnt_q    <= 2'd0;
         af_q[0]       <= '0;
         af_q[1]       <= '0;
         buf_pc_q[0]   <= '0;
         buf_pc_q[1]   <= '0;
         buf_inst_q[0] <= '0;
         buf_inst_q[1] <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         out_cnt_q     <= out_cnt_d;
         occ_q         <= occ_d;
         drop_cnt_q    <= drop_cnt_d;
         af_q[0]       <= af_d[0];
         af_q[1]       <= af_d[1];
         buf_pc_q[0]   <= buf_pc_d[0];
         buf_pc_q[1]   <= buf_pc_d[1];
         buf_inst_q[0] <= buf_inst_d[0];
         buf_inst_q[1] <= buf_inst_d[1];
      end
   end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h8000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter MAX_OUT, default 2, fixed at 2, giving the combined limit on outstanding requests plus buffered instructions.
REQ-003 Port clk, input, 1, SHALL be the single clock, rising-edge.
REQ-004 Port rst, input, 1, SHALL be the reset: one clock, asynchronous, active-high.
REQ-005 Port redirect_vld, input, 1, SHALL signal a taken branch or jump from decode.
REQ-006 Port redirect_pc, input, `CPU_WIDTH, SHALL carry the redirect target.
REQ-007 Port imem_req_vld, output, 1, SHALL signal a fetch request.
REQ-008 Port imem_req_addr, output, `CPU_WIDTH, SHALL carry the fetch address.
REQ-009 Port imem_req_rdy, input, 1, SHALL indicate the memory accepts the request.
REQ-010 Port imem_rsp_vld, input, 1, SHALL signal response data; responses are in order, one per accepted request, latency >=1, and cannot be backpressured.
REQ-011 Port imem_rsp_data, input, `CPU_WIDTH, SHALL carry the instruction word.
REQ-012 Port idu_vld, output, 1, SHALL signal that an instruction is available to decode.
REQ-013 Port idu_inst, output, `CPU_WIDTH, SHALL carry that instruction.
REQ-014 Port idu_inst_pc, output, `CPU_WIDTH, SHALL carry that instruction's address.
REQ-015 Port idu_rdy, input, 1, SHALL indicate decode accepts the instruction.

Function
REQ-016 The block SHALL implement state machine BOOT -> FETCH <-> DRAIN.
- BOOT lasts exactly one cycle after rst deasserts, then goes to FETCH.
REQ-017 The request handshake SHALL complete on imem_req_vld && imem_req_rdy.
- imem_req_vld and imem_req_addr hold stable until accepted, unless redirect_vld is high.
REQ-018 The block SHALL assert imem_req_vld only when:
- state is FETCH, and
- redirect_vld is 0, and
- outstanding + buffer occupancy < MAX_OUT.
REQ-019 The fetch pc SHALL increment by 32'h4 on each accepted request.
- Wraps modulo 2^32, with no flag.
REQ-020 Each accepted address SHALL be pushed into a 2-entry in-flight address FIFO.
- Each response pops that FIFO and pushes {addr, data} into a 2-entry instruction buffer.
REQ-021 idu_vld SHALL equal buffer-not-empty, driven from registers.
- A response is visible on idu_* at the earliest the cycle after imem_rsp_vld.
REQ-022 The buffer head SHALL pop on idu_vld && idu_rdy.
- Simultaneous push and pop on a full buffer is legal: occupancy is unchanged and order is preserved.
REQ-023 On redirect_vld in FETCH, the block SHALL, at the next edge:
- set fetch pc = {redirect_pc[31:2], 2'b00};
- empty the buffer;
- set drop_cnt = outstanding - (imem_rsp_vld ? 1 : 0);
- go to DRAIN if drop_cnt != 0, else stay in FETCH.
REQ-024 A response arriving in the same cycle as redirect_vld SHALL be discarded and SHALL NOT enter the buffer.
REQ-025 In DRAIN, the block SHALL issue no requests and SHALL discard every response, decrementing drop_cnt on each.
- When drop_cnt reaches 0, go to FETCH at the next edge.
REQ-026 A redirect in DRAIN SHALL update the fetch pc only; the last redirect wins, and drop_cnt is unchanged.
REQ-027 A redirect in BOOT SHALL update the fetch pc, and the block SHALL go to FETCH as normal.
REQ-028 An imem_rsp_vld with zero outstanding requests is illegal; the block SHALL ignore it and SHALL NOT change any counter.

Reset
REQ-029 While rst is high, the block SHALL hold:
- state = BOOT, fetch pc = RESET_PC;
- imem_req_vld = 0, imem_req_addr = RESET_PC;
- idu_vld = 0, idu_inst = 0, idu_inst_pc = 0;
- outstanding = 0, occupancy = 0, drop_cnt = 0.
REQ-030 Assertion of rst mid-transaction SHALL abandon all in-flight state immediately.
- Responses after rst deasserts that belong to pre-reset requests are outside this block's contract.

Verification
REQ-031 Sequential fetch
- Stimulus: reset release; imem_req_rdy = 1; memory latency 1; idu_rdy = 1.
- Response: addrs 8000_0000, 8000_0004, 8000_0008 issued in order; idu_inst_pc follows the same sequence with no gaps after warm-up.
REQ-032 Decode stall
- Stimulus: idu_rdy = 0 for 10 cycles.
- Response: exactly 2 instructions buffered; no third request issued; on idu_rdy = 1 the instructions are delivered in order with none lost or duplicated.
REQ-033 Redirect with drop
- Stimulus: 2 requests outstanding; redirect_vld with redirect_pc = 32'h8000_0103.
- Response: both stale responses dropped; the next request addr is 8000_0100; the first idu_inst_pc after the redirect is 8000_0100.
REQ-034 Redirect with simultaneous response
- Stimulus: redirect in the same cycle as imem_rsp_vld with 1 outstanding.
- Response: the response is not delivered; the block stays in FETCH; a request to the target is issued the next cycle.
REQ-035 Backpressure and wrap
- Stimulus: imem_req_rdy held 0 for 5 cycles; separately, RESET_PC = 32'hFFFF_FFFC.
- Response: the address is held stable during backpressure; in the wrap case the second address is 32'h0000_0000.
REQ-036 Async reset mid-DRAIN
- Stimulus: rst asserted between clock edges while in DRAIN.
- Response: outputs reach their reset values without waiting for a clock edge; BOOT lasts 1 cycle, then a request to RESET_PC is issued.
